// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, round constants and the byte S-box.
// The FSM state set depends on AES_KEY_SCHED_REV_EN (adds the SEEK state).
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [31:0] word_t;

`ifdef AES_KEY_SCHED_REV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_EMIT} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_EMIT} state_t;
`endif

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion step; the inverse step exists only
// when AES_KEY_SCHED_REV_EN is defined.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [3:0]   round,
`ifdef AES_KEY_SCHED_REV_EN
    input  logic         inv,
`endif
    output logic [127:0] key_next
);

    word_t w0, w1, w2, w3;
    word_t sub_in, sub_out, t;
    logic [7:0] rc;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];

    // Both directions share the same four S-boxes; only their input word differs.
`ifdef AES_KEY_SCHED_REV_EN
    assign sub_in = inv ? (w3 ^ w2) : w3;
    assign rc     = rcon(inv ? round : round + 4'd1);
`else
    assign sub_in = w3;
    assign rc     = rcon(round + 4'd1);
`endif

    assign sub_out = {sbox(sub_in[23:16]), sbox(sub_in[15:8]),
                      sbox(sub_in[7:0]),   sbox(sub_in[31:24])};
    assign t       = sub_out ^ {rc, 24'h000000};

    always_comb begin
        word_t n0, n1, n2, n3;
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
`ifdef AES_KEY_SCHED_REV_EN
        if (inv) begin
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ t;
        end
`endif
        key_next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready port.
// AES_KEY_SCHED_REV_EN adds the rev input and emits keys 10 down to 0.
module aes_key_sched_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef AES_KEY_SCHED_REV_EN
    input  logic         rev,
`endif
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         busy
);

    state_t       state;
    logic [127:0] key_step;

`ifdef AES_KEY_SCHED_REV_EN
    logic rev_q;

    // SEEK walks forward to round 10 before reverse emission begins.
    aes_key_step u_step (
        .key      (rk_out),
        .round    (rk_idx),
        .inv      (rev_q && state == ST_EMIT),
        .key_next (key_step)
    );
`else
    aes_key_step u_step (
        .key      (rk_out),
        .round    (rk_idx),
        .key_next (key_step)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rk_out   <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
`ifdef AES_KEY_SCHED_REV_EN
            rev_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rk_out  <= key_in;
                        rk_idx  <= '0;
                        rk_last <= 1'b0;
                        busy    <= 1'b1;
`ifdef AES_KEY_SCHED_REV_EN
                        rev_q   <= rev;
                        if (rev) begin
                            state    <= ST_SEEK;
                            rk_valid <= 1'b0;
                        end else begin
                            state    <= ST_EMIT;
                            rk_valid <= 1'b1;
                        end
`else
                        state    <= ST_EMIT;
                        rk_valid <= 1'b1;
`endif
                    end
                end
`ifdef AES_KEY_SCHED_REV_EN
                ST_SEEK: begin
                    rk_out <= key_step;
                    rk_idx <= rk_idx + 4'd1;
                    if (rk_idx == 4'(AES_NR - 1)) begin
                        state    <= ST_EMIT;
                        rk_valid <= 1'b1;
                    end
                end
`endif
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (rk_last) begin
                            state    <= ST_IDLE;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            rk_out <= key_step;
`ifdef AES_KEY_SCHED_REV_EN
                            if (rev_q) begin
                                rk_idx  <= rk_idx - 4'd1;
                                rk_last <= (rk_idx == 4'd1);
                            end else begin
                                rk_idx  <= rk_idx + 4'd1;
                                rk_last <= (rk_idx == 4'(AES_NR - 1));
                            end
`else
                            rk_idx  <= rk_idx + 4'd1;
                            rk_last <= (rk_idx == 4'(AES_NR - 1));
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Scoreboard bench for aes_key_sched_iter using the FIPS-197 example key.
module tb_aes_key_sched_iter;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rev;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    aes_key_sched_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
`ifdef AES_KEY_SCHED_REV_EN
        .rev      (rev),
`endif
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    exp_t         q[$];
    logic [127:0] rk_tab [0:10];
    int           n_cmp = 0;
    int           n_err = 0;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per handshake and checks stall stability.
    logic         stall_prev = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    logic         prev_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rk_valid) begin
            if (stall_prev) begin
                chk("stall_out", rk_out, prev_out);
                chk("stall_idx", 128'(rk_idx), 128'(prev_idx));
                chk("stall_last", 128'(rk_last), 128'(prev_last));
            end
            if (rk_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_key_idx", 128'(rk_idx), 128'hffff);
                end else begin
                    e = q.pop_front();
                    chk("rk_out", rk_out, e.key);
                    chk("rk_idx", 128'(rk_idx), 128'(e.idx));
                    chk("rk_last", 128'(rk_last), 128'(e.last));
                end
            end
        end
        stall_prev = rst_n && rk_valid && !rk_ready;
        prev_out   = rk_out;
        prev_idx   = rk_idx;
        prev_last  = rk_last;
    end

    task automatic push_sched(input bit r);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx  = r ? 4'(10 - i) : 4'(i);
            e.key  = rk_tab[e.idx];
            e.last = (i == 10);
            q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [127:0] k, input bit r);
        @(posedge clk); #1;
        key_in   = k;
        rev      = r;
        rk_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, "_last"},  128'(rk_last),  128'd0);
        chk({tag, "_busy"},  128'(busy),     128'd0);
    endtask

    task automatic run_sched(input bit rand_rdy, input bit coinc, input bit glitch);
        int n = 0;
        bit done = 0;
        bit glitched = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
            start    = 1'b0;
            rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (glitch && !glitched && rk_valid && rk_idx == 4'd5) begin
                start    = 1'b1;
                key_in   = '0;
                glitched = 1;
            end
            if (rk_valid && rk_last && rk_ready) begin
                done = 1;
                if (coinc) begin
                    start  = 1'b1;
                    key_in = '0;
                end
            end
        end
        if (!done) chk("sched_timeout", 128'(n), 128'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk_idle_outputs("after_last");
        chk("queue_drained", 128'(q.size()), 128'd0);
        if (coinc) begin
            repeat (3) @(posedge clk);
            #1;
            chk_idle_outputs("coinc_start_ignored");
        end
    endtask

    initial begin
        int cnt;
        bit found;
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rev      = 1'b0;
        rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", rk_out, 128'd0);
        chk("reset_idx", 128'(rk_idx), 128'd0);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Forward schedule with the consumer always ready
        push_sched(1'b0);
        do_start(FIPS_KEY, 1'b0);
        chk("busy_after_start", 128'(busy), 128'd1);
        chk("valid_after_start", 128'(rk_valid), 128'd1);
        run_sched(1'b0, 1'b0, 1'b0);

        // Random back-pressure
        push_sched(1'b0);
        do_start(FIPS_KEY, 1'b0);
        run_sched(1'b1, 1'b0, 1'b0);

        // Second start with a zero key at idx 5 must be ignored
        push_sched(1'b0);
        do_start(FIPS_KEY, 1'b0);
        run_sched(1'b0, 1'b0, 1'b1);

        // Reset in the middle of a schedule at idx 7
        push_sched(1'b0);
        do_start(FIPS_KEY, 1'b0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #1;
            if (rk_valid && rk_idx == 4'd7) found = 1;
        end
        chk("found_idx7", 128'(found), 128'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out", rk_out, 128'd0);
        chk("midrst_idx", 128'(rk_idx), 128'd0);
        chk_idle_outputs("midrst");
        q.delete();
        rst_n = 1'b1;

        // Restart after reset; start coincident with the final handshake
        push_sched(1'b0);
        do_start(FIPS_KEY, 1'b0);
        run_sched(1'b0, 1'b1, 1'b0);

`ifdef AES_KEY_SCHED_REV_EN
        // Reverse: ten silent seek cycles, then keys 10 down to 0
        push_sched(1'b1);
        do_start(FIPS_KEY, 1'b1);
        cnt = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (rk_valid) found = 1;
            else cnt++;
        end
        chk("rev_seek_cycles", 128'(cnt), 128'd10);
        run_sched(1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
